// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply controller.
package matmul_pkg;
  localparam int DW_DEF = 18;
  localparam int AW_DEF = 5;
  localparam int N_MAX  = 3;
  // Loop counters only ever reach N_MAX-1.
  localparam int CW     = $clog2(N_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with clear/enable and the output mapping f(acc).
// Build option: define MATMUL_SAT_EN to saturate f(acc) to DW bits;
// otherwise f(acc) truncates to the low DW bits.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res
);
  localparam int PW  = 2 * DW;
  localparam int ACW = 2 * DW + 2;

  logic signed [PW-1:0]  a_x, b_x, prod;
  logic signed [ACW-1:0] acc_d, acc_q;

  // Operands sign-extended to full product width so the multiply is exact.
  assign a_x  = {{DW{a[DW-1]}}, a};
  assign b_x  = {{DW{b[DW-1]}}, b};
  assign prod = a_x * b_x;

  // Clear wins over accumulate; two guard bits absorb up to N_MAX products.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + {{2{prod[PW-1]}}, prod};
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

`ifdef MATMUL_SAT_EN
  // In range when every bit above the DW-bit sign position matches the sign.
  always_comb begin
    if (acc_q[ACW-1:DW-1] == {(ACW-DW+1){acc_q[ACW-1]}})
      res = acc_q[DW-1:0];
    else if (acc_q[ACW-1])
      res = {1'b1, {(DW-1){1'b0}}};
    else
      res = {1'b0, {(DW-1){1'b1}}};
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_q[ACW-1:DW];
  assign res = acc_q[DW-1:0];
`endif
endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A*B over NxN matrices in three single-port memories.
// Each C element takes N MAC cycles plus one WRITE cycle.
// Build option: MATMUL_SAT_EN (see matmul_mac) selects saturating output.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int N  = N_MAX,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] data_a,
  input  logic [DW-1:0] data_b,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_c,
  output logic          rd_a,
  output logic          rd_b,
  output logic          wr_c,
  output logic [DW-1:0] data_c,
  output logic          busy,
  output logic          done
);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [AW-1:0] NA   = AW'(N);

  state_e        state_d, state_q;
  logic [CW-1:0] i_d, i_q, j_d, j_q, k_d, k_q;
  logic [DW-1:0] f_acc;
  logic          in_mac, in_wr;

  assign in_mac = (state_q == S_MAC);
  assign in_wr  = (state_q == S_WRITE);

  // Next-state and loop-index update.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_MAC;
        i_d = '0; j_d = '0; k_d = '0;
      end
      S_MAC: begin
        if (abort) begin
          state_d = S_IDLE;
          i_d = '0; j_d = '0; k_d = '0;
        end else if (k_q == LAST) state_d = S_WRITE;
        else                      k_d = k_q + CW'(1);
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
          i_d = '0; j_d = '0; k_d = '0;
        end else begin
          k_d     = '0;
          state_d = S_MAC;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = S_DONE;
            end else i_d = i_q + CW'(1);
          end else j_d = j_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Accumulator stays cleared outside MAC, so each C element starts from 0.
  matmul_mac #(.DW(DW)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (!in_mac),
    .en  (in_mac),
    .a   (data_a),
    .b   (data_b),
    .res (f_acc)
  );

  // Outputs decode only registered state, so reset zeroes them at once.
  assign rd_a   = in_mac;
  assign rd_b   = in_mac;
  assign addr_a = in_mac ? AW'(i_q) * NA + AW'(k_q) : '0;
  assign addr_b = in_mac ? AW'(k_q) * NA + AW'(j_q) : '0;
  assign wr_c   = in_wr;
  assign addr_c = in_wr ? AW'(i_q) * NA + AW'(j_q) : '0;
  assign data_c = in_wr ? f_acc : '0;
  assign busy   = in_mac | in_wr;
  assign done   = (state_q == S_DONE);
endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: a matrix-level model predicts every
// cycle's outputs from the cycle index within an operation.
module tb_matmul_ctrl;
  localparam int N   = 3;
  localparam int DW  = 18;
  localparam int AW  = 5;
  localparam int NN  = N * N;
  localparam int LAT = N * N * (N + 1) + 1;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [DW-1:0] data_a, data_b, data_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic          rd_a, rd_b, wr_c, busy, done;

  longint ma [NN];
  longint mb [NN];
  longint mc [NN];
  int     checks = 0, errors = 0, cyc = 0, wr_count = 0;
  bit     running = 1'b0;

  always #5 clk = ~clk;

  matmul_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .data_a(data_a), .data_b(data_b),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .rd_a(rd_a), .rd_b(rd_b), .wr_c(wr_c), .data_c(data_c),
    .busy(busy), .done(done)
  );

  // Memories: only addresses 0..NN-1 hold data.
  assign data_a = (int'(addr_a) < NN) ? DW'(ma[int'(addr_a)]) : '0;
  assign data_b = (int'(addr_b) < NN) ? DW'(mb[int'(addr_b)]) : '0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic longint fmodel(input longint v);
    longint one, hi, lo, t;
    one = 1;
    hi  = (one <<< (DW - 1)) - 1;
    lo  = -(one <<< (DW - 1));
`ifdef MATMUL_SAT_EN
    t = (v > hi) ? hi : (v < lo) ? lo : v;
`else
    t = v & ((one <<< DW) - 1);
    if (t > hi) t = t - (one <<< DW);
`endif
    return t;
  endfunction

  task automatic compute_c();
    longint s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i*N+k] * mb[k*N+j];
        mc[i*N+j] = fmodel(s);
      end
  endtask

  task automatic fill(input longint va, input longint vb);
    for (int x = 0; x < NN; x++) begin ma[x] = va; mb[x] = vb; end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    longint e_rd, e_aa, e_ab, e_wr, e_ac, e_dc, e_busy, e_done;
    int idx, ph;
    e_rd = 0; e_aa = 0; e_ab = 0; e_wr = 0; e_ac = 0; e_dc = 0;
    e_busy = 0; e_done = 0;
    if (rst) running = 1'b0;
    else if (running) begin
      cyc++;
      if (cyc < LAT) begin
        idx = (cyc - 1) / (N + 1);
        ph  = (cyc - 1) % (N + 1);
        e_busy = 1;
        if (ph < N) begin
          e_rd = 1;
          e_aa = (idx / N) * N + ph;
          e_ab = ph * N + (idx % N);
        end else begin
          e_wr = 1;
          e_ac = idx;
          e_dc = mc[idx];
        end
      end else e_done = 1;
    end
    chk("rd_a",   longint'(rd_a),   e_rd);
    chk("rd_b",   longint'(rd_b),   e_rd);
    chk("addr_a", longint'(addr_a), e_aa);
    chk("addr_b", longint'(addr_b), e_ab);
    chk("wr_c",   longint'(wr_c),   e_wr);
    chk("addr_c", longint'(addr_c), e_ac);
    chk("data_c", longint'($signed(data_c)), e_dc);
    chk("busy",   longint'(busy),   e_busy);
    chk("done",   longint'(done),   e_done);
    if (wr_c) wr_count++;
    if (!rst) begin
      if (running && (cyc >= LAT || abort)) running = 1'b0;
      else if (!running && start) begin running = 1'b1; cyc = 0; end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int t = 0;
    while (!(running && cyc == n) && t < 200) begin @(negedge clk); #1; t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL wait_cyc: cycle %0d not reached, expected within 200", n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (running && t < 200) begin @(negedge clk); #1; t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL wait_idle: still running, expected idle within 200");
    end
    @(negedge clk); #1;
  endtask

  task automatic run_full();
    compute_c();
    wr_count = 0;
    pulse_start();
    wait_idle();
    chk("wr_count", longint'(wr_count), NN);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    fill(0, 0);
    compute_c();
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_wr_c", longint'(wr_c), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Identity * {1..9}
    for (int x = 0; x < NN; x++) begin
      ma[x] = ((x / N) == (x % N)) ? 1 : 0;
      mb[x] = x + 1;
    end
    compute_c();
    chk("model_id4", mc[4], 5);
    chk("model_id8", mc[8], 9);
    run_full();

    // All ones
    fill(1, 1); compute_c();
    chk("model_ones", mc[0], 3);
    run_full();

    // Overflow
    fill(131071, 131071); compute_c();
`ifdef MATMUL_SAT_EN
    chk("model_ovf", mc[3], 131071);
`else
    chk("model_ovf", mc[3], 3);
`endif
    run_full();

    // Negative
    fill(-2, 5); compute_c();
    chk("model_neg", mc[7], -30);
    run_full();

    // Start during busy is ignored
    fill(1, 1); compute_c();
    wr_count = 0;
    pulse_start();
    wait_cyc(4);
    pulse_start();
    wait_idle();
    chk("busy_wr_count", longint'(wr_count), NN);

    // Reset mid-operation: outputs drop without waiting for a clock
    fill(-2, 5); compute_c();
    pulse_start();
    wait_cyc(10);
    #2 rst = 1'b1;
    #1;
    chk("async_rd_a",   longint'(rd_a), 0);
    chk("async_busy",   longint'(busy), 0);
    chk("async_addr_a", longint'(addr_a), 0);
    chk("async_done",   longint'(done), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Abort in a WRITE cycle (cycle 12): write still visible, then IDLE
    fill(1, 1); compute_c();
    pulse_start();
    wait_cyc(11);
    @(posedge clk); #1 abort = 1'b1;
    chk("abort_wr_c", longint'(wr_c), 1);
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle", longint'(busy), 0);
    repeat (3) @(negedge clk);

    // Full run after reset and abort
    fill(-2, 5);
    run_full();

    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
